// File: rtl/alu_arbiter.sv
// Round-robin front end that lets two requesters share one handshaked Hack-style ALU.
// An operation runs grant -> one-cycle ALU clear -> wait for alu_rd_rdy (bounded by TIMEOUT) -> response held until consumed.
module alu_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_x,
  input  logic [15:0] req0_y,
  input  logic [5:0]  req0_ctrl,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_x,
  input  logic [15:0] req1_y,
  input  logic [5:0]  req1_ctrl,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp_out,
  output logic        rsp_zr,
  output logic        rsp_ng,
  output logic        rsp_err,

  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  output logic        alu_reset,
  output logic        alu_ce,

  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  input  logic        alu_rd_rdy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q,   state_d;
  logic        ptr_q,     ptr_d;
  logic        owner_q,   owner_d;
  logic [7:0]  cnt_q,     cnt_d;
  logic [15:0] alu_x_q,   alu_x_d;
  logic [15:0] alu_y_q,   alu_y_d;
  logic [5:0]  ctrl_q,    ctrl_d;
  logic [15:0] rsp_out_q, rsp_out_d;
  logic        rsp_zr_q,  rsp_zr_d;
  logic        rsp_ng_q,  rsp_ng_d;
  logic        rsp_err_q, rsp_err_d;

  logic run;
  logic gnt0;
  logic gnt1;
  logic rsp_take;

  // ptr_q holds the last requester granted; on a tie the other one wins.
  assign run  = ce & ~reset;
  assign gnt1 = req1_valid & (~req0_valid | ~ptr_q);
  assign gnt0 = req0_valid & ~gnt1;

  assign req0_ready = run & (state_q == S_IDLE) & gnt0;
  assign req1_ready = run & (state_q == S_IDLE) & gnt1;

  assign rsp_take = run & (state_q == S_RESP) & (owner_q ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    alu_x_d   = alu_x_q;
    alu_y_d   = alu_y_q;
    ctrl_d    = ctrl_q;
    rsp_out_d = rsp_out_q;
    rsp_zr_d  = rsp_zr_q;
    rsp_ng_d  = rsp_ng_q;
    rsp_err_d = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req0_ready | req1_ready) begin
          owner_d = req1_ready;
          ptr_d   = req1_ready;
          alu_x_d = req1_ready ? req1_x    : req0_x;
          alu_y_d = req1_ready ? req1_y    : req0_y;
          ctrl_d  = req1_ready ? req1_ctrl : req0_ctrl;
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_BUSY;
      end

      S_BUSY: begin
        // A result arriving on the last allowed cycle still counts as success.
        if (alu_rd_rdy) begin
          rsp_out_d = alu_out;
          rsp_zr_d  = alu_zr;
          rsp_ng_d  = alu_ng;
          rsp_err_d = 1'b0;
          state_d   = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_out_d = '0;
          rsp_zr_d  = 1'b0;
          rsp_ng_d  = 1'b0;
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_RESP: begin
        if (rsp_take) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= 1'b1;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      alu_x_q   <= '0;
      alu_y_q   <= '0;
      ctrl_q    <= '0;
      rsp_out_q <= '0;
      rsp_zr_q  <= 1'b0;
      rsp_ng_q  <= 1'b0;
      rsp_err_q <= 1'b0;
    end else if (ce) begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      alu_x_q   <= alu_x_d;
      alu_y_q   <= alu_y_d;
      ctrl_q    <= ctrl_d;
      rsp_out_q <= rsp_out_d;
      rsp_zr_q  <= rsp_zr_d;
      rsp_ng_q  <= rsp_ng_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp0_valid = ~reset & (state_q == S_RESP) & ~owner_q;
  assign rsp1_valid = ~reset & (state_q == S_RESP) &  owner_q;
  assign rsp_out    = rsp_out_q;
  assign rsp_zr     = rsp_zr_q;
  assign rsp_ng     = rsp_ng_q;
  assign rsp_err    = rsp_err_q;

  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign alu_zx    = ctrl_q[5];
  assign alu_nx    = ctrl_q[4];
  assign alu_zy    = ctrl_q[3];
  assign alu_ny    = ctrl_q[2];
  assign alu_f     = ctrl_q[1];
  assign alu_no    = ctrl_q[0];
  assign alu_reset = reset | (state_q == S_CLEAR);
  assign alu_ce    = run & (state_q == S_BUSY);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum cycles spent in BUSY waiting for alu_rd_rdy before aborting (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port ce, input, 1, clock enable; when 0 all state and registered outputs hold.
REQ-005 SHALL have ports reqN_valid, input, 1, requester N (N=0,1) has an operation pending.
REQ-006 SHALL have ports reqN_ready, output, 1, the arbiter accepts requester N's operation this cycle.
REQ-007 SHALL have ports reqN_x and reqN_y, input, 16 each, operands.
REQ-008 SHALL have ports reqN_ctrl, input, 6, ALU control as {zx,nx,zy,ny,f,no} (bit 5 = zx, bit 0 = no).
REQ-009 SHALL have ports rspN_valid, output, 1, result for requester N is available.
REQ-010 SHALL have ports rspN_ready, input, 1, requester N consumes its result.
REQ-011 SHALL have ports rsp_out, output, 16; rsp_zr, output, 1; rsp_ng, output, 1; rsp_err, output, 1 (timeout flag); shared by both requesters, qualified by rspN_valid.
REQ-012 SHALL have ports alu_x and alu_y, output, 16 each; alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, output, 1 each; alu_reset, output, 1; alu_ce, output, 1.
REQ-013 SHALL have ports alu_out, input, 16; alu_zr, alu_ng, alu_rd_rdy, input, 1 each.

Function
REQ-014 SHALL implement FSM states IDLE, CLEAR, BUSY and RESP.
REQ-015 In IDLE with ce=1, SHALL grant one valid requester combinationally: if only one reqN_valid is high, grant it; if both are high, grant the requester not granted last (round-robin pointer).
REQ-016 reqN_ready SHALL be 1 only when state=IDLE, ce=1, reqN_valid=1 and N is granted; at most one reqN_ready SHALL be high per cycle.
REQ-017 On handshake, SHALL register the granted x, y and ctrl onto alu_x, alu_y and alu_zx..alu_no, record the owner, update the round-robin pointer to the owner, and enter CLEAR.
REQ-018 CLEAR SHALL last exactly one cycle with alu_reset=1 and alu_ce=0, then enter BUSY with the wait counter at 0.
REQ-019 In BUSY, SHALL assert alu_ce=1, hold the ALU operand and control outputs stable, and increment the wait counter each ce cycle.
REQ-020 In BUSY, if alu_rd_rdy=1, SHALL capture alu_out, alu_zr and alu_ng into rsp_out, rsp_zr and rsp_ng, set rsp_err=0, and enter RESP.
REQ-021 In BUSY, if alu_rd_rdy=0 while counter=TIMEOUT-1, SHALL set rsp_out=0, rsp_zr=0, rsp_ng=0, rsp_err=1, and enter RESP.
REQ-022 If alu_rd_rdy=1 on the timeout cycle, SHALL treat it as success (REQ-020 takes priority).
REQ-023 In RESP, SHALL assert rspN_valid for the owner only, with alu_ce=0; response outputs SHALL stay stable until rspN_ready=1.
REQ-024 On rspN_ready=1 in RESP, SHALL drop rspN_valid and return to IDLE; the next grant is possible no earlier than the following cycle.
REQ-025 rspN_ready SHALL be ignored outside RESP and for the non-owner.
REQ-026 reqN_valid changes outside IDLE SHALL NOT affect the operation in flight.
REQ-027 With ce=0, SHALL hold state, counter and all registered outputs; reqN_ready SHALL be 0 and alu_ce SHALL be 0.
REQ-028 Best-case latency from the handshake cycle to rspN_valid SHALL be 3 cycles when alu_rd_rdy rises on the first BUSY cycle.

Reset
REQ-029 reset=1 SHALL take precedence over ce and force state IDLE, pointer favouring requester 0, counter 0, and alu_x, alu_y, ALU controls, rsp_out, rsp_zr, rsp_ng and rsp_err to 0.
REQ-030 During reset, reqN_ready, rspN_valid and alu_ce SHALL be 0 and alu_reset SHALL be 1.
REQ-031 Reset asserted mid-operation (CLEAR, BUSY or RESP) SHALL abandon the operation without producing a response.

Verification
REQ-032 Single request: req0 x=5, y=3, ctrl=000010 with alu_rd_rdy=1 on the first BUSY cycle and rsp_ready=1 -> ALU sees x=5, y=3, f=1; rsp0_valid appears 3 cycles after the handshake with rsp_out=8, zr=0, ng=0, err=0.
REQ-033 Contention: both requesters valid continuously after reset -> grants alternate 0,1,0,1; no double ready; each response goes only to its owner.
REQ-034 Timeout: req1 issued, alu_rd_rdy held 0 -> rsp1_valid appears after TIMEOUT BUSY cycles with err=1 and out=0; the next request proceeds normally.
REQ-035 Backpressure: rsp0_ready held 0 for 10 cycles -> rsp0_valid and rsp_out stay stable; req1_ready stays 0 throughout.
REQ-036 ce gating and reset: ce=0 for 5 cycles during BUSY -> counter and outputs frozen; reset pulsed in BUSY -> IDLE next cycle with no rspN_valid.
